dispatch: RTL and testbench

DISPATCH -- requirements
Module: dispatch

---
 rtl/dispatch_if.sv | 30 +++
 rtl/dispatch.sv | 115 +++++++++++
 tb/tb_dispatch.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/dispatch_if.sv
// Dispatch-stage bus: upstream packet handshake, per-slot dispatch outputs and
// issue-queue credit return. The slave modport is the dispatch block itself.
interface dispatch_if #(
  parameter int unsigned PAYLOAD_W = 128,
  parameter int unsigned IQ_DEPTH  = 8
);
  localparam int unsigned CW = $clog2(IQ_DEPTH + 1);

  logic                      flush_i;
  logic                      in_valid_i;
  logic                      in_ready_o;
  logic [1:0]                in_slot_valid_i;
  logic [1:0][1:0]           in_type_i;
  logic [1:0][PAYLOAD_W-1:0] in_payload_i;
  logic [1:0]                disp_valid_o;
  logic [1:0][1:0]           disp_queue_o;
  logic [1:0][PAYLOAD_W-1:0] disp_payload_o;
  logic [2:0][1:0]           iq_release_i;
  logic [2:0][CW-1:0]        credit_o;

  modport slave (
    input  flush_i, in_valid_i, in_slot_valid_i, in_type_i, in_payload_i, iq_release_i,
    output in_ready_o, disp_valid_o, disp_queue_o, disp_payload_o, credit_o
  );

  modport master (
    output flush_i, in_valid_i, in_slot_valid_i, in_type_i, in_payload_i, iq_release_i,
    input  in_ready_o, disp_valid_o, disp_queue_o, disp_payload_o, credit_o
  );
endinterface

// File: rtl/dispatch.sv
// Two-wide in-order dispatch: one holding register feeding ALU/MDU/LSU issue queues,
// gated by per-queue free-entry credits.
module dispatch #(
  parameter int unsigned PAYLOAD_W = 128,
  parameter int unsigned IQ_DEPTH  = 8
) (
  input logic       clk,
  input logic       rst_n,
  dispatch_if.slave bus
);
  localparam int unsigned CW = $clog2(IQ_DEPTH + 1);
  typedef logic [CW:0] wide_t;

  logic [1:0]                held_valid_q;
  logic [1:0][1:0]           held_queue_q;
  logic [1:0][PAYLOAD_W-1:0] held_payload_q;
  logic [2:0][CW-1:0]        credit_q;
  logic [2:0][CW-1:0]        credit_d;

  logic [1:0][1:0] in_queue;
  logic [1:0]      disp;
  logic            accept;
  logic [2:0]      ovf;
  logic [2:0]      unf;
  wide_t           need1;
  int              nxt;

  function automatic logic [CW-1:0] credit_of(input logic [1:0] q,
                                              input logic [2:0][CW-1:0] c);
    case (q)
      2'd1:    return c[1];
      2'd2:    return c[2];
      default: return c[0];
    endcase
  endfunction

  // Type 11 has no queue of its own and is routed to the ALU.
  always_comb begin
    in_queue = '0;
    for (int s = 0; s < 2; s++) begin
      in_queue[s] = (bus.in_type_i[s] == 2'b11) ? 2'b00 : bus.in_type_i[s];
    end
  end

  always_comb begin
    disp    = '0;
    need1   = '0;
    disp[0] = !bus.flush_i && held_valid_q[0] &&
              (credit_of(held_queue_q[0], credit_q) != '0);
    // Slot 1 needs a second credit when both slots target the same queue.
    need1   = wide_t'(1) + wide_t'(disp[0] && (held_queue_q[0] == held_queue_q[1]));
    disp[1] = !bus.flush_i && held_valid_q[1] && (disp[0] || !held_valid_q[0]) &&
              ({1'b0, credit_of(held_queue_q[1], credit_q)} >= need1);
  end

  assign accept = bus.in_valid_i && bus.in_ready_o;

  always_comb begin
    credit_d = credit_q;
    ovf      = '0;
    unf      = '0;
    nxt      = 0;
    for (int q = 0; q < 3; q++) begin
      nxt = int'(credit_q[q])
            - int'(disp[0] && (held_queue_q[0] == 2'(q)))
            - int'(disp[1] && (held_queue_q[1] == 2'(q)))
            + int'(bus.iq_release_i[q]);
      ovf[q] = nxt > int'(IQ_DEPTH);
      unf[q] = nxt < 0;
      if (ovf[q]) begin
        credit_d[q] = CW'(IQ_DEPTH);
      end else if (unf[q]) begin
        credit_d[q] = '0;
      end else begin
        credit_d[q] = CW'(nxt);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      held_valid_q <= '0;
      credit_q     <= {3{CW'(IQ_DEPTH)}};
    end else if (bus.flush_i) begin
      held_valid_q <= '0;
      credit_q     <= {3{CW'(IQ_DEPTH)}};
    end else begin
      credit_q <= credit_d;
      if (accept) begin
        held_valid_q   <= bus.in_slot_valid_i;
        held_queue_q   <= in_queue;
        held_payload_q <= bus.in_payload_i;
      end else begin
        held_valid_q <= held_valid_q & ~disp;
      end
    end
  end

  // Credit return beyond capacity or an illegal release value means the queues lost sync.
  always_ff @(posedge clk) begin
    if (rst_n && !bus.flush_i) begin
      assert (ovf == '0 && unf == '0);
      assert (bus.iq_release_i[0] != 2'b11 && bus.iq_release_i[1] != 2'b11 &&
              bus.iq_release_i[2] != 2'b11);
    end
  end

  assign bus.in_ready_o     = !bus.flush_i && (!held_valid_q[0] || disp[0]) &&
                              (!held_valid_q[1] || disp[1]);
  assign bus.disp_valid_o   = disp;
  assign bus.disp_queue_o   = held_queue_q;
  assign bus.disp_payload_o = held_payload_q;
  assign bus.credit_o       = credit_q;

endmodule

// File: tb/tb_dispatch.sv
// Directed bench for dispatch: hand-computed credit/dispatch expectations plus a short
// randomised run checked against a queue-occupancy and ordering model.
module tb_dispatch;
  localparam int unsigned PW = 16;
  localparam int unsigned D  = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dispatch_if #(.PAYLOAD_W(PW), .IQ_DEPTH(D)) bus ();

  dispatch #(.PAYLOAD_W(PW), .IQ_DEPTH(D)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [1:0] sv, input logic [1:0] t0, input logic [1:0] t1,
                      input logic [PW-1:0] p0, input logic [PW-1:0] p1);
    bus.in_valid_i      = 1'b1;
    bus.in_slot_valid_i = sv;
    bus.in_type_i[0]    = t0;
    bus.in_type_i[1]    = t1;
    bus.in_payload_i[0] = p0;
    bus.in_payload_i[1] = p1;
    tick();
    bus.in_valid_i      = 1'b0;
    bus.in_slot_valid_i = 2'b00;
  endtask

  task automatic check_credits(input string tag, input int a, input int m, input int l);
    check({tag, "_alu"}, 64'(bus.credit_o[0]), 64'(a));
    check({tag, "_mdu"}, 64'(bus.credit_o[1]), 64'(m));
    check({tag, "_lsu"}, 64'(bus.credit_o[2]), 64'(l));
  endtask

  logic [PW-1:0] fifo[$];
  int            occ[3];
  int            rel[3];
  logic [PW-1:0] exp_p;
  int            q;

  initial begin
    bus.flush_i         = 1'b0;
    bus.in_valid_i      = 1'b0;
    bus.in_slot_valid_i = '0;
    bus.in_type_i       = '0;
    bus.in_payload_i    = '0;
    bus.iq_release_i    = '0;

    tick();
    tick();
    rst_n = 1'b1;
    #1;
    check("rst_ready", 64'(bus.in_ready_o), 64'd1);
    check("rst_disp", 64'(bus.disp_valid_o), 64'd0);
    check_credits("rst", 8, 8, 8);

    // {ALU, LSU} accepted, dispatched the next cycle.
    send(2'b11, 2'd0, 2'd2, 16'hA000, 16'hA001);
    #1;
    check("p1_disp", 64'(bus.disp_valid_o), 64'b11);
    check("p1_queue", 64'(bus.disp_queue_o), 64'b1000);
    check("p1_pay0", 64'(bus.disp_payload_o[0]), 64'hA000);
    check("p1_pay1", 64'(bus.disp_payload_o[1]), 64'hA001);
    tick();
    check("p1_after", 64'(bus.disp_valid_o), 64'd0);
    check_credits("p1", 7, 8, 7);

    // Stream three {ALU,ALU} packets: ALU credit 7 -> 1.
    for (int i = 0; i < 3; i++) send(2'b11, 2'd0, 2'd0, 16'(i), 16'(i + 16));
    tick();
    check_credits("alu1", 1, 8, 7);

    // One ALU credit: slot 0 leaves, slot 1 held until a release arrives.
    send(2'b11, 2'd0, 2'd0, 16'hB000, 16'hB001);
    #1;
    check("part_disp", 64'(bus.disp_valid_o), 64'b01);
    check("part_ready", 64'(bus.in_ready_o), 64'd0);
    tick();
    bus.iq_release_i[0] = 2'd1;
    #1;
    check("rel_same_cyc", 64'(bus.disp_valid_o), 64'b00);
    tick();
    bus.iq_release_i[0] = 2'd0;
    #1;
    check("part2_disp", 64'(bus.disp_valid_o), 64'b10);
    check("part2_ready", 64'(bus.in_ready_o), 64'd1);
    check("part2_pay", 64'(bus.disp_payload_o[1]), 64'hB001);
    tick();
    check_credits("part2", 0, 8, 7);

    bus.iq_release_i[0] = 2'd2;
    tick();
    bus.iq_release_i[0] = 2'd0;
    for (int i = 0; i < 4; i++) send(2'b11, 2'd1, 2'd1, 16'hC000, 16'hC001);
    tick();
    check_credits("mdu0", 2, 0, 7);

    // MDU empty: younger ALU slot blocked behind the older MDU slot.
    send(2'b11, 2'd1, 2'd0, 16'hD000, 16'hD001);
    #1;
    check("blk_disp", 64'(bus.disp_valid_o), 64'b00);
    check("blk_ready", 64'(bus.in_ready_o), 64'd0);
    tick();
    bus.iq_release_i[1] = 2'd1;
    #1;
    check("blk_disp2", 64'(bus.disp_valid_o), 64'b00);
    tick();
    bus.iq_release_i[1] = 2'd0;
    #1;
    check("unblk_disp", 64'(bus.disp_valid_o), 64'b11);
    check("unblk_queue", 64'(bus.disp_queue_o), 64'b0001);
    tick();
    check_credits("unblk", 1, 0, 7);

    // Type 11 routes to the ALU.
    send(2'b01, 2'd3, 2'd0, 16'hE000, 16'hE001);
    #1;
    check("t3_disp", 64'(bus.disp_valid_o), 64'b01);
    check("t3_queue", 64'(bus.disp_queue_o[0]), 64'b00);
    tick();

    // LSU 7 -> 5, then one LSU dispatch with release 2: 5 - 1 + 2 = 6.
    send(2'b11, 2'd2, 2'd2, 16'hF000, 16'hF001);
    tick();
    send(2'b01, 2'd2, 2'd0, 16'hF002, 16'h0);
    bus.iq_release_i[2] = 2'd2;
    #1;
    check("lsu_disp", 64'(bus.disp_valid_o), 64'b01);
    tick();
    bus.iq_release_i[2] = 2'd0;
    check_credits("lsu", 0, 0, 6);

    // ALU credit 0 holds {ALU,ALU}; flush discards it and refills credits.
    send(2'b11, 2'd0, 2'd0, 16'h1111, 16'h2222);
    bus.flush_i         = 1'b1;
    bus.in_valid_i      = 1'b1;
    bus.in_slot_valid_i = 2'b11;
    bus.iq_release_i[1] = 2'd1;
    #1;
    check("flush_disp", 64'(bus.disp_valid_o), 64'b00);
    check("flush_ready", 64'(bus.in_ready_o), 64'd0);
    tick();
    bus.flush_i         = 1'b0;
    bus.in_valid_i      = 1'b0;
    bus.in_slot_valid_i = 2'b00;
    bus.iq_release_i    = '0;
    #1;
    check("postflush_disp", 64'(bus.disp_valid_o), 64'b00);
    check("postflush_ready", 64'(bus.in_ready_o), 64'd1);
    check_credits("postflush", 8, 8, 8);

    // Random traffic against an occupancy + ordering model.
    for (int i = 0; i < 3; i++) occ[i] = 0;
    for (int c = 0; c < 300; c++) begin
      bus.in_valid_i      = 1'($urandom_range(0, 1));
      bus.in_slot_valid_i = 2'($urandom_range(0, 3));
      bus.in_type_i[0]    = 2'($urandom_range(0, 3));
      bus.in_type_i[1]    = 2'($urandom_range(0, 3));
      bus.in_payload_i[0] = 16'($urandom);
      bus.in_payload_i[1] = 16'($urandom);
      for (int k = 0; k < 3; k++) begin
        rel[k] = $urandom_range(0, (occ[k] < 2) ? occ[k] : 2);
        bus.iq_release_i[k] = 2'(rel[k]);
      end
      #1;
      for (int k = 0; k < 3; k++) check("occ_inv", 64'(int'(bus.credit_o[k]) + occ[k]), 64'(D));
      for (int s = 0; s < 2; s++) begin
        if (bus.disp_valid_o[s]) begin
          if (fifo.size() == 0) begin
            check("order_empty", 64'(fifo.size()), 64'd1);
          end else begin
            exp_p = fifo.pop_front();
            check("order", 64'(bus.disp_payload_o[s]), 64'(exp_p));
          end
          q = int'(bus.disp_queue_o[s]);
          if (q < 3) occ[q]++;
          else check("queue_range", 64'(q), 64'd0);
        end
      end
      for (int k = 0; k < 3; k++) occ[k] -= rel[k];
      if (bus.in_valid_i && bus.in_ready_o) begin
        if (bus.in_slot_valid_i[0]) fifo.push_back(bus.in_payload_i[0]);
        if (bus.in_slot_valid_i[1]) fifo.push_back(bus.in_payload_i[1]);
      end
      tick();
    end
    bus.in_valid_i   = 1'b0;
    bus.iq_release_i = '0;

    // Reset mid-operation drops a held packet without dispatching it.
    send(2'b11, 2'd0, 2'd0, 16'h3333, 16'h4444);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    check("rst2_disp", 64'(bus.disp_valid_o), 64'b00);
    check("rst2_ready", 64'(bus.in_ready_o), 64'd1);
    check_credits("rst2", 8, 8, 8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
